slc3_button_ctrl: RTL and testbench
===================================

SLC3_BUTTON_CTRL -- requirements
Module: slc3_button_ctrl

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flip-flop synchronizer stages per button input (minimum 2).
REQ-002 Parameter: DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized cycles required before a debounced level changes (minimum 1).
REQ-003 Port: Clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 Port: Reset, input, 1, asynchronous, active-high reset.
REQ-005 Port: Run_n, input, 1, raw Run pushbutton, active-low, asynchronous to Clk.
REQ-006 Port: Continue_n, input, 1, raw Continue pushbutton, active-low, asynchronous to Clk.
REQ-007 Port: Pause_req, input, 1, high while the CPU FSM sits in a pause state awaiting Continue.
REQ-008 Port: Run_pulse, output, 1, one-cycle strobe per accepted Run press.
REQ-009 Port: Continue_pulse, output, 1, one-cycle strobe releasing the CPU from pause.
REQ-010 Port: Combo_reset, output, 1, high while both buttons are debounced-pressed.
REQ-011 Port: Cont_pending, output, 1, high while a Continue press is latched and awaiting Pause_req.

Function
REQ-012 Each raw input SHALL pass through SYNC_STAGES flip-flops, reset to 1 (released), before any other use.
REQ-013 Each button SHALL have a debounce counter; the debounced level toggles only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any intermediate match clears the counter to 0.
REQ-014 Debounced levels SHALL be internal, active-high "pressed" signals, reset to 0.
REQ-015 Run_pulse SHALL assert for exactly one cycle, the cycle after debounced Run goes 0->1, unless debounced Continue is 1 in that cycle.
REQ-016 Total latency from a clean raw press to Run_pulse SHALL be SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges.
REQ-017 Combo_reset SHALL be registered and equal to (debounced Run AND debounced Continue), delayed one cycle.
REQ-018 The Continue FSM SHALL have three states: IDLE, PEND, HOLD; reset state IDLE.
REQ-019 In IDLE, on a debounced Continue 0->1 edge: if Pause_req=1, assert Continue_pulse next cycle and go to HOLD; else go to PEND.
REQ-020 In PEND, Cont_pending=1; when Pause_req=1, assert Continue_pulse next cycle and go to HOLD; additional presses SHALL NOT queue.
REQ-021 In HOLD, no further Continue_pulse SHALL be issued; return to IDLE only when Pause_req=0 and debounced Continue=0 in the same cycle.
REQ-022 Continue_pulse SHALL never exceed one cycle per FSM pass through HOLD.
REQ-023 While Combo_reset=1, the FSM SHALL be forced to IDLE and Run_pulse, Continue_pulse and Cont_pending SHALL be 0.
REQ-024 A debounced Continue edge in the same cycle as debounced Run at 1 SHALL be ignored (combo press, not Continue).
REQ-025 A release (1->0) of either debounced level SHALL generate no pulse.

Reset
REQ-026 Asserting Reset SHALL immediately clear all outputs to 0, set synchronizers to released, set debounce counters and levels to 0, and put the FSM in IDLE, regardless of the state in progress.
REQ-027 After Reset deasserts with buttons held, a press SHALL be recognized once debounced, with no spurious pulse from reset release itself.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-028 Run_n falls and stays low -> Run_pulse high for exactly one cycle, 7 edges after the first sampling edge; nothing further while held.
REQ-029 Run_n toggles every 2 cycles for 20 cycles, then stays high -> no Run_pulse, debounced level stays 0.
REQ-030 Pause_req=0, Continue press -> Cont_pending=1, no pulse; raise Pause_req -> Continue_pulse next cycle, Cont_pending=0, FSM in HOLD; second press while in HOLD -> no pulse.
REQ-031 Pause_req=1, Continue press then release, Pause_req drops -> exactly one Continue_pulse, FSM back to IDLE.
REQ-032 Both buttons pressed within 2 cycles -> Combo_reset=1 while held, no Run_pulse or Continue_pulse, FSM in IDLE.
REQ-033 Reset asserted mid-debounce and in PEND -> all outputs 0 asynchronously; after release, held button produces one pulse after full latency.

Source files
------------

// File: rtl/slc3_button_ctrl.sv
// slc3_button_ctrl
//   Front-panel button handling for the SLC-3 CPU. Two raw active-low
//   pushbuttons (Run, Continue) are synchronized, debounced and turned into
//   single-cycle strobes. A small FSM latches a Continue press until the CPU
//   is actually waiting in a pause state. Holding both buttons at once is a
//   "combo" that suppresses all strobes and raises Combo_reset.
//
// Parameters
//   SYNC_STAGES     flip-flop synchronizer depth per button (>= 2)
//   DEBOUNCE_CYCLES consecutive stable cycles before a debounced level flips (>= 1)
//
// Ports
//   Clk            system clock, rising edge
//   Reset          asynchronous, active-high
//   Run_n          raw Run button, active-low, asynchronous
//   Continue_n     raw Continue button, active-low, asynchronous
//   Pause_req      CPU is parked in a pause state awaiting Continue
//   Run_pulse      one-cycle strobe per accepted Run press
//   Continue_pulse one-cycle strobe releasing the CPU from pause
//   Combo_reset    both buttons debounced-pressed (registered)
//   Cont_pending   a Continue press is latched, waiting for Pause_req

module slc3_button_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run_n,
    input  logic Continue_n,
    input  logic Pause_req,
    output logic Run_pulse,
    output logic Continue_pulse,
    output logic Combo_reset,
    output logic Cont_pending
);

    localparam int RUN  = 0;
    localparam int CONT = 1;

    localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    logic [1:0]             btn_n;
    logic [SYNC_STAGES-1:0] sync_p [2];
    logic [CNT_W-1:0]       cnt    [2];
    logic [1:0]             db_p0;      // debounced "pressed" levels
    logic [1:0]             db_p1;      // debounced levels delayed one cycle
    logic                   run_rise;
    logic                   cont_rise;
    logic                   run_pulse_q;
    logic                   cont_pulse_q;
    logic                   combo_q;
    logic                   fire;
    state_t                 state;
    state_t                 state_nxt;

    assign btn_n = {Continue_n, Run_n};

    // Stage: synchronizer chain and debounce counters (p0), edge history (p1)
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                sync_p[i] <= '1;
                cnt[i]    <= '0;
            end
            db_p0 <= '0;
            db_p1 <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_p[i] <= {sync_p[i][SYNC_STAGES-2:0], btn_n[i]};
                // The level flips only after the synchronized value has
                // disagreed with it for DEBOUNCE_CYCLES cycles in a row;
                // any agreeing cycle restarts the count.
                if (~sync_p[i][SYNC_STAGES-1] != db_p0[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        db_p0[i] <= ~db_p0[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
            db_p1 <= db_p0;
        end
    end

    // Only press edges matter; releases never produce a strobe.
    assign run_rise  = db_p0[RUN]  & ~db_p1[RUN];
    assign cont_rise = db_p0[CONT] & ~db_p1[CONT];

    // Stage: registered strobes and combo detect
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            run_pulse_q  <= 1'b0;
            cont_pulse_q <= 1'b0;
            combo_q      <= 1'b0;
        end else begin
            // A Run edge while Continue is held is a combo press, not a Run.
            run_pulse_q  <= run_rise & ~db_p0[CONT] & ~combo_q;
            cont_pulse_q <= fire;
            combo_q      <= db_p0[RUN] & db_p0[CONT];
        end
    end

    // Continue FSM: state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Continue FSM: next state. 'fire' requests the strobe for the next
    // cycle and is only raised on entry to HOLD, so one strobe per pass.
    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        if (combo_q) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cont_rise && !db_p0[RUN]) begin
                        if (Pause_req) begin
                            state_nxt = HOLD;
                            fire      = 1'b1;
                        end else begin
                            state_nxt = PEND;
                        end
                    end
                end
                PEND: begin
                    // Further presses are absorbed here; nothing queues.
                    if (Pause_req) begin
                        state_nxt = HOLD;
                        fire      = 1'b1;
                    end
                end
                HOLD: begin
                    if (!Pause_req && !db_p0[CONT]) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Continue FSM: outputs, all blanked while the combo is active
    always_comb begin
        Combo_reset    = combo_q;
        Run_pulse      = run_pulse_q & ~combo_q;
        Continue_pulse = cont_pulse_q & ~combo_q;
        Cont_pending   = (state == PEND) & ~combo_q;
    end

endmodule

// File: tb/tb_slc3_button_ctrl.sv
// Testbench for slc3_button_ctrl with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Expected strobe cycles are queued when a button is driven; a monitor
// records the cycle of every observed strobe and each scenario task
// compares the two queues.

module tb_slc3_button_ctrl;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LAT  = SYNC + DEB + 1;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic Run_n = 1'b1;
    logic Continue_n = 1'b1;
    logic Pause_req = 1'b0;
    logic Run_pulse;
    logic Continue_pulse;
    logic Combo_reset;
    logic Cont_pending;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int run_obs[$];
    int cont_obs[$];
    int run_exp[$];
    int cont_exp[$];

    slc3_button_ctrl #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Run_n         (Run_n),
        .Continue_n    (Continue_n),
        .Pause_req     (Pause_req),
        .Run_pulse     (Run_pulse),
        .Continue_pulse(Continue_pulse),
        .Combo_reset   (Combo_reset),
        .Cont_pending  (Cont_pending)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Run_pulse === 1'b1)      run_obs.push_back(cyc);
        if (Continue_pulse === 1'b1) cont_obs.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic clear_queues();
        run_obs.delete();
        cont_obs.delete();
        run_exp.delete();
        cont_exp.delete();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #12;
        checks++;
        if (Run_pulse !== 1'b0 || Continue_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses got run=%b cont=%b want 0 0", Run_pulse, Continue_pulse);
        end
        checks++;
        if (Combo_reset !== 1'b0 || Cont_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_levels got combo=%b pend=%b want 0 0", Combo_reset, Cont_pending);
        end
        tick(2);
        clear_queues();
        Reset = 1'b0;
        tick(12);
        checks++;
        if (run_obs.size() != 0 || cont_obs.size() != 0) begin
            errors++;
            $display("FAIL reset_release_pulses got run=%0d cont=%0d want 0 0", run_obs.size(), cont_obs.size());
        end
        checks++;
        if (Combo_reset !== 1'b0 || Cont_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_levels got combo=%b pend=%b want 0 0", Combo_reset, Cont_pending);
        end
    endtask

    task automatic test_run_press();
        int c0;
        clear_queues();
        c0 = cyc;
        Run_n = 1'b0;
        run_exp.push_back(c0 + LAT);
        tick(25);
        Run_n = 1'b1;
        tick(15);
        checks++;
        if (run_obs.size() != run_exp.size()) begin
            errors++;
            $display("FAIL run_press_count got %0d want %0d", run_obs.size(), run_exp.size());
        end
        while (run_obs.size() > 0 && run_exp.size() > 0) begin
            int a;
            int e;
            a = run_obs.pop_front();
            e = run_exp.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL run_press_cycle got %0d want %0d", a, e);
            end
        end
        checks++;
        if (cont_obs.size() != 0) begin
            errors++;
            $display("FAIL run_press_cont_pulse got %0d want 0", cont_obs.size());
        end
    endtask

    task automatic test_bounce();
        logic saw;
        saw = 1'b0;
        clear_queues();
        for (int i = 0; i < 10; i++) begin
            Run_n = ~Run_n;
            repeat (2) begin
                @(negedge Clk);
                if (dut.db_p0[0] !== 1'b0) saw = 1'b1;
            end
        end
        Run_n = 1'b1;
        tick(15);
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL bounce_level got %b want 0", saw);
        end
        checks++;
        if (run_obs.size() != 0) begin
            errors++;
            $display("FAIL bounce_pulses got %0d want 0", run_obs.size());
        end
    endtask

    task automatic test_cont_pend();
        int c1;
        clear_queues();
        Pause_req = 1'b0;
        Continue_n = 1'b0;
        tick(LAT + 2);
        checks++;
        if (Cont_pending !== 1'b1) begin
            errors++;
            $display("FAIL pend_set got %b want 1", Cont_pending);
        end
        Continue_n = 1'b1;
        tick(10);
        Continue_n = 1'b0;
        tick(10);
        checks++;
        if (Cont_pending !== 1'b1 || cont_obs.size() != 0) begin
            errors++;
            $display("FAIL pend_repress got pend=%b pulses=%0d want 1 0", Cont_pending, cont_obs.size());
        end
        c1 = cyc;
        Pause_req = 1'b1;
        cont_exp.push_back(c1 + 1);
        tick(1);
        checks++;
        if (Cont_pending !== 1'b0 || Continue_pulse !== 1'b1) begin
            errors++;
            $display("FAIL pend_release got pend=%b pulse=%b want 0 1", Cont_pending, Continue_pulse);
        end
        Continue_n = 1'b1;
        tick(10);
        Continue_n = 1'b0;
        tick(15);
        checks++;
        if (cont_obs.size() != cont_exp.size()) begin
            errors++;
            $display("FAIL pend_count got %0d want %0d", cont_obs.size(), cont_exp.size());
        end
        while (cont_obs.size() > 0 && cont_exp.size() > 0) begin
            int a;
            int e;
            a = cont_obs.pop_front();
            e = cont_exp.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL pend_cycle got %0d want %0d", a, e);
            end
        end
        Continue_n = 1'b1;
        Pause_req = 1'b0;
        tick(10);
        checks++;
        if (Cont_pending !== 1'b0 || run_obs.size() != 0) begin
            errors++;
            $display("FAIL pend_cleanup got pend=%b run=%0d want 0 0", Cont_pending, run_obs.size());
        end
    endtask

    task automatic test_cont_pause();
        int c0;
        int c2;
        clear_queues();
        Pause_req = 1'b1;
        tick(1);
        c0 = cyc;
        Continue_n = 1'b0;
        cont_exp.push_back(c0 + LAT);
        tick(12);
        Continue_n = 1'b1;
        tick(10);
        Pause_req = 1'b0;
        tick(5);
        // A fresh press with no pause pending is only latched from IDLE.
        Continue_n = 1'b0;
        tick(LAT + 2);
        checks++;
        if (Cont_pending !== 1'b1) begin
            errors++;
            $display("FAIL pause_back_idle got pend=%b want 1", Cont_pending);
        end
        c2 = cyc;
        Pause_req = 1'b1;
        cont_exp.push_back(c2 + 1);
        tick(3);
        Continue_n = 1'b1;
        tick(10);
        Pause_req = 1'b0;
        tick(5);
        checks++;
        if (cont_obs.size() != cont_exp.size()) begin
            errors++;
            $display("FAIL pause_count got %0d want %0d", cont_obs.size(), cont_exp.size());
        end
        while (cont_obs.size() > 0 && cont_exp.size() > 0) begin
            int a;
            int e;
            a = cont_obs.pop_front();
            e = cont_exp.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL pause_cycle got %0d want %0d", a, e);
            end
        end
    endtask

    task automatic test_combo();
        clear_queues();
        Pause_req = 1'b0;
        Run_n = 1'b0;
        Continue_n = 1'b0;
        tick(LAT - 1);
        checks++;
        if (Combo_reset !== 1'b0) begin
            errors++;
            $display("FAIL combo_early got %b want 0", Combo_reset);
        end
        tick(1);
        checks++;
        if (Combo_reset !== 1'b1) begin
            errors++;
            $display("FAIL combo_rise got %b want 1", Combo_reset);
        end
        tick(10);
        checks++;
        if (Combo_reset !== 1'b1 || Cont_pending !== 1'b0) begin
            errors++;
            $display("FAIL combo_held got combo=%b pend=%b want 1 0", Combo_reset, Cont_pending);
        end
        Run_n = 1'b1;
        Continue_n = 1'b1;
        tick(LAT + 1);
        checks++;
        if (Combo_reset !== 1'b0 || Cont_pending !== 1'b0) begin
            errors++;
            $display("FAIL combo_release got combo=%b pend=%b want 0 0", Combo_reset, Cont_pending);
        end
        checks++;
        if (run_obs.size() != 0 || cont_obs.size() != 0) begin
            errors++;
            $display("FAIL combo_pulses got run=%0d cont=%0d want 0 0", run_obs.size(), cont_obs.size());
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        clear_queues();
        Pause_req = 1'b0;
        Continue_n = 1'b0;
        tick(LAT + 2);
        checks++;
        if (Cont_pending !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pend got %b want 1", Cont_pending);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (Cont_pending !== 1'b0 || Run_pulse !== 1'b0 || Continue_pulse !== 1'b0 || Combo_reset !== 1'b0) begin
            errors++;
            $display("FAIL rmid_pend_async got pend=%b run=%b cont=%b combo=%b want 0 0 0 0",
                     Cont_pending, Run_pulse, Continue_pulse, Combo_reset);
        end
        Continue_n = 1'b1;
        tick(2);
        Reset = 1'b0;
        tick(LAT + 3);
        Run_n = 1'b0;
        tick(3);
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (dut.db_p0 !== 2'b00 || Run_pulse !== 1'b0 || Cont_pending !== 1'b0) begin
            errors++;
            $display("FAIL rmid_deb_async got db=%b run=%b pend=%b want 00 0 0", dut.db_p0, Run_pulse, Cont_pending);
        end
        tick(2);
        c0 = cyc;
        Reset = 1'b0;
        run_exp.push_back(c0 + LAT);
        tick(LAT + 10);
        Run_n = 1'b1;
        tick(10);
        checks++;
        if (run_obs.size() != run_exp.size()) begin
            errors++;
            $display("FAIL rmid_count got %0d want %0d", run_obs.size(), run_exp.size());
        end
        while (run_obs.size() > 0 && run_exp.size() > 0) begin
            int a;
            int e;
            a = run_obs.pop_front();
            e = run_exp.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL rmid_cycle got %0d want %0d", a, e);
            end
        end
        checks++;
        if (cont_obs.size() != 0) begin
            errors++;
            $display("FAIL rmid_cont_pulses got %0d want 0", cont_obs.size());
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_run_press();
        test_bounce();
        test_cont_pend();
        test_cont_pause();
        test_combo();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
